// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions used by decode, the register file and the
// write-back arbiter: datapath widths, load funct3 codes, requester IDs
// and the load-width extension helper.
package regfile_wb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int IDX_W   = 5;
  localparam int NUM_REQ = 3;

  // Requester identities on the write-back port
  localparam int REQ_ROB = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_ALU = 2;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Sign/zero extension of a raw result according to its load width.
  // Unknown codes pass the word through untouched.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] funct3,
                                                  input logic [XLEN-1:0] d);
    case (funct3)
      F3_LB:   extend_load = {{(XLEN-8){d[7]}}, d[7:0]};
      F3_LH:   extend_load = {{(XLEN-16){d[15]}}, d[15:0]};
      F3_LBU:  extend_load = {{(XLEN-8){1'b0}}, d[7:0]};
      F3_LHU:  extend_load = {{(XLEN-16){1'b0}}, d[15:0]};
      F3_LW:   extend_load = d;
      default: extend_load = d;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between the requesters and the arbiter.
//   req_valid  per-requester request
//   req_ready  per-requester grant (transfer = valid && ready)
//   req_index  packed destination register indices
//   req_data   packed raw result words
//   req_type   packed funct3 load-width codes
// master: requester side; slave: arbiter side.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = NUM_REQ,
  parameter int DW    = XLEN,
  parameter int IW    = IDX_W
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*IW-1:0] req_index;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ*3-1:0]  req_type;

  modport master (output req_valid, req_index, req_data, req_type, input req_ready);
  modport slave  (input req_valid, req_index, req_data, req_type, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Generic round-robin arbiter.
//   clk, rst_n  clock, async active-low reset (pointer -> 0)
//   req         request vector
//   advance     a grant was accepted this cycle; move pointer past winner
//   grant       one-hot grant, first requester at or after the pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gnt_idx_s;
  logic [PW:0]   scan_s;
  logic          found_s;

  // Rotating-priority scan: first request at ptr, ptr+1, ... modulo N
  always_comb begin
    grant     = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    scan_s    = '0;
    for (int i = 0; i < N; i++) begin
      scan_s = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan_s >= N_W) begin
        scan_s = scan_s - N_W;
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && req[scan_s[PW-1:0]]) begin
        grant[scan_s[PW-1:0]] = 1'b1;
        gnt_idx_s             = scan_s[PW-1:0];
        found_s               = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the accepted winner, wrapping at N
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_s) begin
      if (gnt_idx_s == PW'(N-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: shares the single regfile write port
// between NUM_REQ requesters (0 = ROB commit, 1 = LSU, 2 = ALU).
//   clk, rst_n  clock, async active-low reset
//   flush       squash: no grant this cycle, write stage loads idle
//   wb          request bus (slave side)
//   wr_en/wr_index/wr_data  registered regfile write port, 1 cycle after grant
//   busy_mask   registers targeted by any valid request (x0 excluded)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ_P = NUM_REQ,
  parameter int XLEN_P    = XLEN,
  parameter int IDX_W_P   = IDX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  regfile_wb_arbiter_if.slave       wb,
  output logic                      wr_en,
  output logic [IDX_W_P-1:0]        wr_index,
  output logic [XLEN_P-1:0]         wr_data,
  output logic [31:0]               busy_mask
);
  logic [NUM_REQ_P-1:0] req_s;
  logic [NUM_REQ_P-1:0] grant_s;
  logic                 transfer_s;
  logic [IDX_W_P-1:0]   sel_index_s;
  logic [XLEN_P-1:0]    sel_data_s;
  logic [2:0]           sel_type_s;
  logic [XLEN_P-1:0]    ext_data_s;
  logic [31:0]          busy_s;

  logic                 wr_en_q, wr_en_d;
  logic [IDX_W_P-1:0]   wr_index_q, wr_index_d;
  logic [XLEN_P-1:0]    wr_data_q, wr_data_d;

  // Flush hides every request from the arbiter, so neither ready nor the
  // pointer advance can happen in a squashed cycle.
  assign req_s      = wb.req_valid & {NUM_REQ_P{~flush}};
  assign transfer_s = |grant_s;

  rr_arbiter #(.N(NUM_REQ_P)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_s),
    .advance (transfer_s),
    .grant   (grant_s)
  );

  // Ready is held low for the whole time reset is asserted.
  assign wb.req_ready = grant_s & {NUM_REQ_P{rst_n}};

  // Select the granted request; grant is one-hot so an AND-OR mux suffices
  always_comb begin
    sel_index_s = '0;
    sel_data_s  = '0;
    sel_type_s  = 3'b000;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      sel_index_s = sel_index_s | (wb.req_index[i*IDX_W_P +: IDX_W_P] & {IDX_W_P{grant_s[i]}});
      sel_data_s  = sel_data_s  | (wb.req_data[i*XLEN_P +: XLEN_P]    & {XLEN_P{grant_s[i]}});
      sel_type_s  = sel_type_s  | (wb.req_type[i*3 +: 3]              & {3{grant_s[i]}});
    end
  end

  assign ext_data_s = extend_load(sel_type_s, sel_data_s);

  // Write stage next state: x0 transfers are accepted but never written
  always_comb begin
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    if (transfer_s && (sel_index_s != '0)) begin
      wr_en_d    = 1'b1;
      wr_index_d = sel_index_s;
      wr_data_d  = ext_data_s;
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Write stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_index = wr_index_q;
  assign wr_data  = wr_data_q;

  // Scoreboard view: every register some valid request targets, x0 never
  always_comb begin
    busy_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      if (wb.req_valid[i]) begin
        busy_s[wb.req_index[i*IDX_W_P +: IDX_W_P]] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
    busy_s[0] = 1'b0;
  end

  assign busy_mask = busy_s;

endmodule
